// File: rtl/alu_input_debounce_pkg.sv
// Shared definitions for the board-input conditioning block: defaults,
// the per-bit qualification state names and the counter-width helper.
package alu_input_debounce_pkg;

    // Three board switches/buttons feed the ALU operands and op select.
    localparam int DEFAULT_WIDTH         = 3;
    // Consecutive synchronized cycles a new level must hold to be accepted.
    localparam int DEFAULT_STABLE_CYCLES = 16;

    // Implicit per-bit state: derived from (s2 != db), never stored.
    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_QUALIFY = 1'b1
    } db_state_e;

    // Counter width able to hold 0 .. stable_cycles-1. Never below one bit,
    // so the degenerate minimum of 2 still yields a usable register.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_input_debounce_bit.sv
// Single-bit conditioner: two-flop synchronizer, qualification counter,
// debounced level and one-cycle rise/fall pulses. The combinational next
// pulse values are exported so the parent can register an aggregate strobe
// on the same edge as the per-bit pulses.
module debounce_bit
    import alu_input_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_d_o,
    output logic fall_d_o
);

    localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    db_state_e        cur_state;

    // Qualification: count while the synchronized level disagrees with the
    // accepted level; accept and pulse once the count has run its full length.
    always_comb begin
        cur_state = (s2_q != db_q) ? DB_QUALIFY : DB_IDLE;
        cnt_d     = cnt_q;
        db_d      = db_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (cur_state)
            DB_IDLE: begin
                // Any return to the accepted level aborts qualification.
                cnt_d = '0;
            end
            DB_QUALIFY: begin
                if (cnt_q == CNT_MAX) begin
                    // Clearing on acceptance keeps the counter from wrapping.
                    db_d   = s2_q;
                    cnt_d  = '0;
                    rise_d = s2_q;
                    fall_d = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // All per-bit state, cleared asynchronously so a reset never emits a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_o     = db_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign rise_d_o = rise_d;
    assign fall_d_o = fall_d;

endmodule

// File: rtl/alu_input_debounce.sv
// Board-input conditioner for the ALU: one independent debounce_bit per
// input line plus a registered any_change strobe that downstream uses to
// re-latch operands. any_change is built from the per-bit next-pulse values
// so it rises on the same edge as the rise_p/fall_p bits it summarizes.
module alu_input_debounce
    import alu_input_debounce_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_p,
    output logic [WIDTH-1:0] fall_p,
    output logic             any_change
);

    logic [WIDTH-1:0] rise_d_vec;
    logic [WIDTH-1:0] fall_d_vec;
    logic             any_change_q;
    logic             any_change_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_debounce_bit (
                .clk      (clk),
                .rst_n    (rst_n),
                .raw_i    (raw_in[gi]),
                .db_o     (db_out[gi]),
                .rise_o   (rise_p[gi]),
                .fall_o   (fall_p[gi]),
                .rise_d_o (rise_d_vec[gi]),
                .fall_d_o (fall_d_vec[gi])
            );
        end
    endgenerate

    // Simultaneous acceptances on several bits collapse into one strobe.
    always_comb begin
        any_change_d = |{rise_d_vec, fall_d_vec};
    end

    // Aggregate strobe, registered alongside the per-bit pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_alu_input_debounce.sv
// Bench for alu_input_debounce with WIDTH=3, STABLE_CYCLES=4. Directed
// scenarios check hand-derived edge timing; a randomized run compares the
// DUT against a sliding-window reference: the accepted level flips once the
// last STABLE_CYCLES synchronized samples (raw delayed by two edges) all
// disagree with it.
module tb_alu_input_debounce;

    localparam int W  = 3;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_p;
    logic [W-1:0] fall_p;
    logic         any_change;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_input_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_p     (rise_p),
        .fall_p     (fall_p),
        .any_change (any_change)
    );

    // Reference model: history of raw samples, newest at index 0.
    logic [W-1:0] m_hist [0:SC];
    logic [W-1:0] m_db, m_rise, m_fall;
    logic         m_any;
    logic [W-1:0] m_all_hi, m_all_lo;

    always_comb begin
        m_all_hi = '1;
        m_all_lo = '1;
        for (int j = 1; j <= SC; j++) begin
            m_all_hi = m_all_hi & m_hist[j];
            m_all_lo = m_all_lo & ~m_hist[j];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= SC; j++) m_hist[j] <= '0;
            m_db   <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_any  <= 1'b0;
        end else begin
            m_rise <= m_all_hi & ~m_db;
            m_fall <= m_all_lo & m_db;
            m_db   <= (m_db | (m_all_hi & ~m_db)) & ~(m_all_lo & m_db);
            m_any  <= |((m_all_hi & ~m_db) | (m_all_lo & m_db));
            for (int j = SC; j >= 1; j--) m_hist[j] <= m_hist[j-1];
            m_hist[0] <= raw_in;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_db, exp_r;
        rst_n  = 1'b0;
        raw_in = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if ({db_out, rise_p, fall_p, any_change} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {db_out, rise_p, fall_p, any_change});
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_db = (e >= 6) ? 3'b111 : 3'b000;
            exp_r  = (e == 6) ? 3'b111 : 3'b000;
            checks++;
            if (db_out !== exp_db) begin
                errors++;
                $display("FAIL reset_release_db edge %0d got %b want %b", e, db_out, exp_db);
            end
            checks++;
            if (rise_p !== exp_r || fall_p !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_pulse edge %0d got rise %b fall %b want rise %b fall 000", e, rise_p, fall_p, exp_r);
            end
            checks++;
            if (any_change !== (e == 6)) begin
                errors++;
                $display("FAIL reset_release_any edge %0d got %b want %b", e, any_change, (e == 6));
            end
        end
    endtask

    task automatic test_step();
        logic [W-1:0] exp_db, exp_r;
        @(negedge clk);
        raw_in = 3'b000;
        repeat (12) step();
        checks++;
        if (db_out !== 3'b000) begin
            errors++;
            $display("FAIL step_settle_low got %b want 000", db_out);
        end
        @(negedge clk);
        raw_in = 3'b001;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_db = (e >= 6) ? 3'b001 : 3'b000;
            exp_r  = (e == 6) ? 3'b001 : 3'b000;
            checks++;
            if (db_out !== exp_db) begin
                errors++;
                $display("FAIL step_db edge %0d got %b want %b", e, db_out, exp_db);
            end
            checks++;
            if (rise_p !== exp_r || fall_p !== 3'b000 || any_change !== (e == 6)) begin
                errors++;
                $display("FAIL step_pulse edge %0d got rise %b fall %b any %b want rise %b fall 000 any %b",
                         e, rise_p, fall_p, any_change, exp_r, (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            raw_in = (k < 3) ? 3'b011 : 3'b001;
            step();
            checks++;
            if (db_out !== 3'b001 || rise_p !== 3'b000 || fall_p !== 3'b000 || any_change !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle %0d got db %b rise %b fall %b any %b want db 001 no pulses",
                         k, db_out, rise_p, fall_p, any_change);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0]   pat;
        logic [W-1:0] exp_db, exp_r;
        int           pulses;
        pat    = 6'b101101;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            raw_in = {((k < 6) ? pat[k] : 1'b1), 2'b01};
            step();
            if (rise_p[2]) pulses++;
            exp_db = (k >= 10) ? 3'b101 : 3'b001;
            exp_r  = (k == 10) ? 3'b100 : 3'b000;
            checks++;
            if (db_out !== exp_db || rise_p !== exp_r || fall_p !== 3'b000 || any_change !== (k == 10)) begin
                errors++;
                $display("FAIL bounce cycle %0d got db %b rise %b fall %b any %b want db %b rise %b fall 000 any %b",
                         k, db_out, rise_p, fall_p, any_change, exp_db, exp_r, (k == 10));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_simultaneous_fall();
        logic [W-1:0] exp_db, exp_f;
        int           any_cnt;
        any_cnt = 0;
        @(negedge clk);
        raw_in = 3'b000;
        for (int k = 0; k < 9; k++) begin
            step();
            if (any_change) any_cnt++;
            exp_db = (k >= 5) ? 3'b000 : 3'b101;
            exp_f  = (k == 5) ? 3'b101 : 3'b000;
            checks++;
            if (db_out !== exp_db || fall_p !== exp_f || rise_p !== 3'b000 || any_change !== (k == 5)) begin
                errors++;
                $display("FAIL simul_fall cycle %0d got db %b rise %b fall %b any %b want db %b rise 000 fall %b any %b",
                         k, db_out, rise_p, fall_p, any_change, exp_db, exp_f, (k == 5));
            end
            if (k < 8) @(negedge clk);
        end
        checks++;
        if (any_cnt != 1) begin
            errors++;
            $display("FAIL simul_fall_any_count got %0d want 1", any_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        raw_in = 3'b001;
        repeat (8) step();
        checks++;
        if (db_out !== 3'b001) begin
            errors++;
            $display("FAIL async_setup got %b want 001", db_out);
        end
        @(negedge clk);
        raw_in = 3'b000;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({db_out, rise_p, fall_p, any_change} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_immediate got %b want 0", {db_out, rise_p, fall_p, any_change});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({db_out, rise_p, fall_p, any_change} !== 10'b0) begin
                errors++;
                $display("FAIL async_after_release cycle %0d got %b want 0", k, {db_out, rise_p, fall_p, any_change});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        v = raw_in;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            end
            raw_in = v;
            step();
            checks++;
            if (db_out !== m_db || rise_p !== m_rise || fall_p !== m_fall || any_change !== m_any) begin
                errors++;
                $display("FAIL random cycle %0d got db %b rise %b fall %b any %b want db %b rise %b fall %b any %b",
                         k, db_out, rise_p, fall_p, any_change, m_db, m_rise, m_fall, m_any);
            end
            checks++;
            if ((rise_p & fall_p) !== 3'b000) begin
                errors++;
                $display("FAIL random_rise_and_fall cycle %0d got %b want 000", k, rise_p & fall_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_bounce();
        test_simultaneous_fall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
